// File: rtl/scaler_mode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scaler_mode_ctrl_pkg
// Shared video package: default active-video geometry, the scaler reset
// pulse length, the mode-control FSM state encoding and a saturating
// counter helper shared by the timing measurement path.
// ---------------------------------------------------------------------------
package scaler_mode_ctrl_pkg;

    // Counter width used for all line/pixel measurements.
    localparam int          CNT_W          = 12;
    localparam logic [11:0] CNT_MAX        = 12'd4095;

    // Default expected active video geometry.
    localparam logic [11:0] H_ACT_DEF      = 12'd640;
    localparam logic [11:0] V_ACT_DEF      = 12'd720;

    // Default length of the scaler reset pulse issued on a mode switch.
    localparam int          RST_CYCLES_DEF = 16;

    // Mode-control FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MEASURE = 3'd1,
        RUN     = 3'd2,
        PEND    = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [11:0] sat_inc(input logic [11:0] value);
        logic [11:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 12'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/scaler_mode_ctrl_timing_meas.sv
// ---------------------------------------------------------------------------
// video_timing_meas
// Measures active line length and active line count of the incoming video
// and decides whether the timing matches the expected H_ACT x V_ACT frame.
// After LOCK_FRAMES consecutive matching frames timing_lock is raised.
//
// Ports
//   clk         in   pixel clock
//   rst_n       in   async active-low reset
//   clr         in   synchronous clear of all measurement state
//   vs_in       in   vsync, active high
//   de_in       in   data enable
//   vs_rise     out  vsync rising edge strobe (combinational, same cycle)
//   h_act_meas  out  length of the last completed active line
//   v_act_meas  out  active line count of the last completed frame
//   timing_lock out  LOCK_FRAMES consecutive matching frames seen
// ---------------------------------------------------------------------------
module video_timing_meas
    import scaler_mode_ctrl_pkg::*;
#(
    parameter logic [11:0] H_ACT       = H_ACT_DEF,
    parameter logic [11:0] V_ACT       = V_ACT_DEF,
    parameter int          LOCK_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        vs_in,
    input  logic        de_in,
    output logic        vs_rise,
    output logic [11:0] h_act_meas,
    output logic [11:0] v_act_meas,
    output logic        timing_lock
);

    localparam int            LW       = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

    logic          de_d_r;
    logic          vs_d_r;
    logic [11:0]   h_cnt_r;
    logic [11:0]   v_cnt_r;
    logic [11:0]   h_meas_r;
    logic [11:0]   v_meas_r;
    logic          mism_r;
    logic [LW-1:0] lock_cnt_r;
    logic          lock_r;

    logic          de_fall_s;
    logic          vs_rise_s;
    logic          line_bad_s;
    logic [11:0]   v_close_s;
    logic          frame_ok_s;
    logic [LW-1:0] lock_nxt_s;

    // Edge detection, frame-match decision and next lock count.
    always_comb begin
        de_fall_s  = de_d_r & ~de_in;
        vs_rise_s  = vs_in & ~vs_d_r;
        line_bad_s = de_fall_s & (h_cnt_r != H_ACT);
        // A line ending in the vsync cycle still belongs to the closing frame,
        // so it is folded into both the line count and the match decision.
        if (de_fall_s) begin
            v_close_s = sat_inc(v_cnt_r);
        end else begin
            v_close_s = v_cnt_r;
        end
        frame_ok_s = (v_close_s == V_ACT) & ~mism_r & ~line_bad_s;
        if (vs_rise_s) begin
            if (!frame_ok_s) begin
                lock_nxt_s = '0;
            end else if (lock_cnt_r == LOCK_MAX) begin
                lock_nxt_s = lock_cnt_r;
            end else begin
                lock_nxt_s = lock_cnt_r + LW'(1);
            end
        end else begin
            lock_nxt_s = lock_cnt_r;
        end
    end

    // Measurement counters, latched results and lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d_r     <= 1'b0;
            vs_d_r     <= 1'b0;
            h_cnt_r    <= 12'd0;
            v_cnt_r    <= 12'd0;
            h_meas_r   <= 12'd0;
            v_meas_r   <= 12'd0;
            mism_r     <= 1'b0;
            lock_cnt_r <= '0;
            lock_r     <= 1'b0;
        end else if (clr) begin
            de_d_r     <= 1'b0;
            vs_d_r     <= 1'b0;
            h_cnt_r    <= 12'd0;
            v_cnt_r    <= 12'd0;
            h_meas_r   <= 12'd0;
            v_meas_r   <= 12'd0;
            mism_r     <= 1'b0;
            lock_cnt_r <= '0;
            lock_r     <= 1'b0;
        end else begin
            de_d_r <= de_in;
            vs_d_r <= vs_in;
            if (de_in) begin
                h_cnt_r <= sat_inc(h_cnt_r);
            end else begin
                h_cnt_r <= 12'd0;
            end
            if (de_fall_s) begin
                h_meas_r <= h_cnt_r;
            end
            if (vs_rise_s) begin
                v_meas_r <= v_close_s;
                v_cnt_r  <= 12'd0;
                mism_r   <= 1'b0;
            end else begin
                v_cnt_r <= v_close_s;
                if (line_bad_s) begin
                    mism_r <= 1'b1;
                end
            end
            lock_cnt_r <= lock_nxt_s;
            lock_r     <= (lock_nxt_s == LOCK_MAX);
        end
    end

    assign vs_rise     = vs_rise_s;
    assign h_act_meas  = h_meas_r;
    assign v_act_meas  = v_meas_r;
    assign timing_lock = lock_r;

endmodule

// File: rtl/scaler_mode_ctrl.sv
// ---------------------------------------------------------------------------
// scaler_mode_ctrl
// Chooses between bypass and scaled mode for the downstream scaler. Mode
// changes are only applied on a frame boundary (vsync rising edge) and are
// followed by a RST_CYCLES long scaler reset. Loss of input timing forces
// bypass; loss of init_over_tx returns everything to its idle state.
//
// Ports
//   pixclk_in    in   sole clock
//   rst_n        in   async active-low reset
//   init_over_tx in   TX init done, synchronous enable
//   vs_in        in   vsync, active high
//   de_in        in   data enable
//   mode_req     in   asynchronous level, 1 = scaled mode requested
//   mode_active  out  applied mode (scaler_ctrl)
//   scaler_rst_n out  active-low scaler reset
//   timing_lock  out  input timing matches H_ACT x V_ACT
//   mode_busy    out  mode change pending or flushing
//   h_act_meas   out  last measured active line length
//   v_act_meas   out  last measured active line count
// ---------------------------------------------------------------------------
module scaler_mode_ctrl
    import scaler_mode_ctrl_pkg::*;
#(
    parameter logic [11:0] H_ACT       = H_ACT_DEF,
    parameter logic [11:0] V_ACT       = V_ACT_DEF,
    parameter int          LOCK_FRAMES = 3,
    parameter int          RST_CYCLES  = RST_CYCLES_DEF
) (
    input  logic        pixclk_in,
    input  logic        rst_n,
    input  logic        init_over_tx,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic        mode_req,
    output logic        mode_active,
    output logic        scaler_rst_n,
    output logic        timing_lock,
    output logic        mode_busy,
    output logic [11:0] h_act_meas,
    output logic [11:0] v_act_meas
);

    localparam int            FW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(RST_CYCLES - 1);

    logic [1:0]    mode_sync_r;
    logic          mode_req_s;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [FW-1:0] flush_cnt_r;
    logic [FW-1:0] flush_cnt_nxt_s;
    logic          mode_active_r;
    logic          mode_active_nxt_s;
    logic          scaler_rst_n_r;
    logic          scaler_rst_n_nxt_s;
    logic          mode_busy_r;
    logic          mode_busy_nxt_s;
    logic          vs_rise_s;
    logic          timing_lock_s;

    video_timing_meas #(
        .H_ACT       (H_ACT),
        .V_ACT       (V_ACT),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_meas (
        .clk         (pixclk_in),
        .rst_n       (rst_n),
        .clr         (~init_over_tx),
        .vs_in       (vs_in),
        .de_in       (de_in),
        .vs_rise     (vs_rise_s),
        .h_act_meas  (h_act_meas),
        .v_act_meas  (v_act_meas),
        .timing_lock (timing_lock_s)
    );

    // Two-flop synchroniser for the asynchronous mode request.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_r <= 2'b00;
        end else begin
            mode_sync_r <= {mode_sync_r[0], mode_req};
        end
    end

    assign mode_req_s = mode_sync_r[1];

    // Next-state logic and flush counter.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        if (!init_over_tx) begin
            state_nxt_s     = IDLE;
            flush_cnt_nxt_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = MEASURE;
                end
                MEASURE: begin
                    if (timing_lock_s) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = MEASURE;
                    end
                end
                RUN: begin
                    if (!timing_lock_s) begin
                        state_nxt_s = MEASURE;
                    end else if (mode_req_s != mode_active_r) begin
                        state_nxt_s = PEND;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                PEND: begin
                    if (!timing_lock_s) begin
                        state_nxt_s = MEASURE;
                    end else if (mode_req_s == mode_active_r) begin
                        state_nxt_s = RUN;
                    end else if (vs_rise_s) begin
                        state_nxt_s     = FLUSH;
                        flush_cnt_nxt_s = FLUSH_LOAD;
                    end else begin
                        state_nxt_s = PEND;
                    end
                end
                FLUSH: begin
                    // The flush always runs to completion; a timing loss seen
                    // meanwhile only redirects the exit to MEASURE.
                    if (flush_cnt_r == '0) begin
                        if (timing_lock_s) begin
                            state_nxt_s = RUN;
                        end else begin
                            state_nxt_s = MEASURE;
                        end
                    end else begin
                        state_nxt_s     = FLUSH;
                        flush_cnt_nxt_s = flush_cnt_r - FW'(1);
                    end
                end
                default: begin
                    state_nxt_s     = IDLE;
                    flush_cnt_nxt_s = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with state_r.
    always_comb begin
        mode_active_nxt_s  = mode_active_r;
        scaler_rst_n_nxt_s = 1'b1;
        mode_busy_nxt_s    = 1'b0;
        if ((state_nxt_s == IDLE) || (state_nxt_s == MEASURE)) begin
            mode_active_nxt_s = 1'b0;
        end else if ((state_r == PEND) && (state_nxt_s == FLUSH)) begin
            mode_active_nxt_s = ~mode_active_r;
        end else begin
            mode_active_nxt_s = mode_active_r;
        end
        if ((state_nxt_s == IDLE) || (state_nxt_s == FLUSH)) begin
            scaler_rst_n_nxt_s = 1'b0;
        end else if ((state_r == RUN) && vs_rise_s) begin
            // One-cycle per-frame restart of the scaler.
            scaler_rst_n_nxt_s = 1'b0;
        end else begin
            scaler_rst_n_nxt_s = 1'b1;
        end
        if ((state_nxt_s == PEND) || (state_nxt_s == FLUSH)) begin
            mode_busy_nxt_s = 1'b1;
        end else begin
            mode_busy_nxt_s = 1'b0;
        end
    end

    // State, flush counter and registered outputs.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            flush_cnt_r    <= '0;
            mode_active_r  <= 1'b0;
            scaler_rst_n_r <= 1'b0;
            mode_busy_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            flush_cnt_r    <= flush_cnt_nxt_s;
            mode_active_r  <= mode_active_nxt_s;
            scaler_rst_n_r <= scaler_rst_n_nxt_s;
            mode_busy_r    <= mode_busy_nxt_s;
        end
    end

    assign mode_active  = mode_active_r;
    assign scaler_rst_n = scaler_rst_n_r;
    assign mode_busy    = mode_busy_r;
    assign timing_lock  = timing_lock_s;

endmodule

// File: tb/tb_scaler_mode_ctrl.sv
// Testbench for scaler_mode_ctrl with a reduced 16x8 frame geometry.
module tb_scaler_mode_ctrl;
    import scaler_mode_ctrl_pkg::*;

    localparam logic [11:0] TB_H    = 12'd16;
    localparam logic [11:0] TB_V    = 12'd8;
    localparam int          TB_LOCK = 3;
    localparam int          TB_RST  = 16;

    logic        pixclk_in = 1'b0;
    logic        rst_n, init_over_tx, vs_in, de_in, mode_req;
    logic        mode_active, scaler_rst_n, timing_lock, mode_busy;
    logic [11:0] h_act_meas, v_act_meas;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: per-frame bookkeeping of the input video.
    int m_lines, m_h, m_v, m_lock;
    bit m_bad;

    // scaler_rst_n low-pulse monitor.
    int pulse_cnt = 0;
    int last_low  = 0;
    int low_run   = 0;

    always #5 pixclk_in = ~pixclk_in;

    scaler_mode_ctrl #(
        .H_ACT(TB_H), .V_ACT(TB_V), .LOCK_FRAMES(TB_LOCK), .RST_CYCLES(TB_RST)
    ) dut (
        .pixclk_in(pixclk_in), .rst_n(rst_n), .init_over_tx(init_over_tx),
        .vs_in(vs_in), .de_in(de_in), .mode_req(mode_req),
        .mode_active(mode_active), .scaler_rst_n(scaler_rst_n),
        .timing_lock(timing_lock), .mode_busy(mode_busy),
        .h_act_meas(h_act_meas), .v_act_meas(v_act_meas)
    );

    always @(negedge pixclk_in) begin
        if (scaler_rst_n === 1'b0) begin
            low_run <= low_run + 1;
        end else if (low_run != 0) begin
            pulse_cnt <= pulse_cnt + 1;
            last_low  <= low_run;
            low_run   <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pixclk_in);
    endtask

    task automatic model_reset();
        m_lines = 0; m_bad = 0; m_lock = 0; m_h = 0; m_v = 0;
    endtask

    task automatic model_line(input int len);
        m_h = (len > 4095) ? 4095 : len;
        m_lines++;
        if (m_h != int'(TB_H)) m_bad = 1;
    endtask

    task automatic model_close();
        m_v = m_lines;
        if (m_lines == int'(TB_V) && !m_bad) m_lock = (m_lock < TB_LOCK) ? m_lock + 1 : TB_LOCK;
        else m_lock = 0;
        m_lines = 0; m_bad = 0;
    endtask

    task automatic send_line(input int len);
        de_in = 1'b1;
        tick(len);
        de_in = 1'b0;
        model_line(len);
        tick($urandom_range(2, 5));
    endtask

    task automatic send_vs();
        vs_in = 1'b1;
        model_close();
        tick(2);
        vs_in = 1'b0;
        tick(22);
    endtask

    // Last active line ends in the very cycle vsync rises.
    task automatic send_line_coinc(input int len);
        de_in = 1'b1;
        tick(len);
        de_in = 1'b0;
        vs_in = 1'b1;
        model_line(len);
        model_close();
        tick(2);
        vs_in = 1'b0;
        tick(22);
    endtask

    task automatic send_frame();
        for (int i = 0; i < int'(TB_V); i++) send_line(int'(TB_H));
        send_vs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_over_tx = 1'b0; vs_in = 1'b0; de_in = 1'b0; mode_req = 1'b0;
        model_reset();
        tick(3);
        total++; if ({mode_active, scaler_rst_n, timing_lock, mode_busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {mode_active, scaler_rst_n, timing_lock, mode_busy}); end
        total++; if ({h_act_meas, v_act_meas} !== 24'd0) begin
            bad++; $display("FAIL reset_meas: got h=%0d v=%0d want 0/0", h_act_meas, v_act_meas); end
        total++; if (dut.state_r !== IDLE) begin
            bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state_r); end
    endtask

    task automatic test_lock();
        int p0;
        rst_n = 1'b1; init_over_tx = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame();
            total++; if (h_act_meas !== 12'(m_h) || v_act_meas !== 12'(m_v)) begin
                bad++; $display("FAIL lock_meas: got h=%0d v=%0d want %0d/%0d", h_act_meas, v_act_meas, m_h, m_v); end
            total++; if (timing_lock !== (m_lock == TB_LOCK)) begin
                bad++; $display("FAIL lock_flag f%0d: got %b want %b", f, timing_lock, m_lock == TB_LOCK); end
        end
        total++; if (timing_lock !== 1'b1) begin
            bad++; $display("FAIL lock_third: got %b want 1", timing_lock); end
        total++; if (dut.state_r !== RUN || mode_busy !== 1'b0 || mode_active !== 1'b0 || scaler_rst_n !== 1'b1) begin
            bad++; $display("FAIL lock_run: got st=%0d busy=%b act=%b srst=%b want RUN/0/0/1", dut.state_r, mode_busy, mode_active, scaler_rst_n); end
        p0 = pulse_cnt;
        send_frame();
        total++; if (pulse_cnt - p0 != 1 || last_low != 1) begin
            bad++; $display("FAIL frame_pulse: got n=%0d len=%0d want 1/1", pulse_cnt - p0, last_low); end
    endtask

    task automatic test_cancel();
        int k, p0;
        k = $urandom_range(1, int'(TB_V) - 2);
        for (int i = 0; i < k; i++) send_line(int'(TB_H));
        mode_req = 1'b1;
        tick(5);
        total++; if (mode_busy !== 1'b1) begin
            bad++; $display("FAIL cancel_busy: got %b want 1", mode_busy); end
        mode_req = 1'b0;
        tick(5);
        total++; if (mode_busy !== 1'b0) begin
            bad++; $display("FAIL cancel_idle: got %b want 0", mode_busy); end
        p0 = pulse_cnt;
        for (int i = k; i < int'(TB_V); i++) send_line(int'(TB_H));
        send_vs();
        total++; if (mode_active !== 1'b0 || pulse_cnt - p0 != 1 || last_low != 1) begin
            bad++; $display("FAIL cancel_noflush: got act=%b n=%0d len=%0d want 0/1/1", mode_active, pulse_cnt - p0, last_low); end
    endtask

    task automatic test_mode_switch();
        int k, p0;
        k = $urandom_range(1, int'(TB_V) - 2);
        for (int i = 0; i < k; i++) send_line(int'(TB_H));
        mode_req = 1'b1;
        tick(5);
        total++; if (mode_busy !== 1'b1 || mode_active !== 1'b0) begin
            bad++; $display("FAIL switch_pend: got busy=%b act=%b want 1/0", mode_busy, mode_active); end
        for (int i = k; i < int'(TB_V); i++) send_line(int'(TB_H));
        total++; if (mode_active !== 1'b0) begin
            bad++; $display("FAIL switch_midframe: got %b want 0", mode_active); end
        p0 = pulse_cnt;
        send_vs();
        total++; if (mode_active !== 1'b1 || pulse_cnt - p0 != 1 || last_low != TB_RST) begin
            bad++; $display("FAIL switch_flush: got act=%b n=%0d len=%0d want 1/1/%0d", mode_active, pulse_cnt - p0, last_low, TB_RST); end
        total++; if (mode_busy !== 1'b0 || dut.state_r !== RUN) begin
            bad++; $display("FAIL switch_done: got busy=%b st=%0d want 0/RUN", mode_busy, dut.state_r); end
    endtask

    task automatic test_timing_fault();
        int bi;
        bi = $urandom_range(0, int'(TB_V) - 1);
        for (int i = 0; i < int'(TB_V); i++) send_line((i == bi) ? int'(TB_H) - 1 : int'(TB_H));
        send_vs();
        total++; if (h_act_meas !== 12'(m_h) || v_act_meas !== 12'(m_v)) begin
            bad++; $display("FAIL fault_meas: got h=%0d v=%0d want %0d/%0d", h_act_meas, v_act_meas, m_h, m_v); end
        total++; if (timing_lock !== 1'b0 || mode_active !== 1'b0 || dut.state_r !== MEASURE) begin
            bad++; $display("FAIL fault_bypass: got lock=%b act=%b st=%0d want 0/0/MEASURE", timing_lock, mode_active, dut.state_r); end
        for (int f = 0; f < 3; f++) begin
            send_frame();
            total++; if (timing_lock !== (m_lock == TB_LOCK)) begin
                bad++; $display("FAIL relock f%0d: got %b want %b", f, timing_lock, m_lock == TB_LOCK); end
        end
        total++; if (dut.state_r !== PEND || mode_busy !== 1'b1) begin
            bad++; $display("FAIL relock_pend: got st=%0d busy=%b want PEND/1", dut.state_r, mode_busy); end
        send_frame();
        total++; if (mode_active !== 1'b1 || mode_busy !== 1'b0) begin
            bad++; $display("FAIL relock_switch: got act=%b busy=%b want 1/0", mode_active, mode_busy); end
    endtask

    task automatic test_abort(input bit use_rst);
        mode_req = use_rst;
        tick(5);
        total++; if (mode_busy !== 1'b1) begin
            bad++; $display("FAIL abort_pend%0d: got %b want 1", use_rst, mode_busy); end
        for (int i = 0; i < int'(TB_V); i++) send_line(int'(TB_H));
        vs_in = 1'b1;
        tick(5);
        total++; if (dut.state_r !== FLUSH || scaler_rst_n !== 1'b0) begin
            bad++; $display("FAIL abort_flush%0d: got st=%0d srst=%b want FLUSH/0", use_rst, dut.state_r, scaler_rst_n); end
        if (use_rst) begin
            #1 rst_n = 1'b0;
            #2;
        end else begin
            init_over_tx = 1'b0;
            tick(3);
        end
        total++; if ({mode_active, scaler_rst_n, timing_lock, mode_busy} !== 4'b0000 || {h_act_meas, v_act_meas} !== 24'd0) begin
            bad++; $display("FAIL abort_out%0d: got flags=%b h=%0d v=%0d want 0000/0/0", use_rst,
                {mode_active, scaler_rst_n, timing_lock, mode_busy}, h_act_meas, v_act_meas); end
        total++; if (dut.state_r !== IDLE) begin
            bad++; $display("FAIL abort_state%0d: got %0d want IDLE", use_rst, dut.state_r); end
        tick(3);
        vs_in = 1'b0;
        tick(2);
        rst_n = 1'b1; init_over_tx = 1'b1;
        model_reset();
        for (int f = 0; f < 3; f++) send_frame();
        total++; if (timing_lock !== 1'b1 || h_act_meas !== 12'(m_h) || v_act_meas !== 12'(m_v)) begin
            bad++; $display("FAIL abort_relock%0d: got lock=%b h=%0d v=%0d want 1/%0d/%0d", use_rst, timing_lock, h_act_meas, v_act_meas, m_h, m_v); end
        total++; if (mode_busy !== use_rst || dut.state_r !== (use_rst ? PEND : RUN)) begin
            bad++; $display("FAIL abort_after%0d: got busy=%b st=%0d want %b", use_rst, mode_busy, dut.state_r, use_rst); end
    endtask

    task automatic test_coincident();
        for (int i = 0; i < int'(TB_V) - 1; i++) send_line(int'(TB_H));
        send_vs();
        total++; if (timing_lock !== 1'b0 || mode_active !== 1'b0 || dut.state_r !== MEASURE) begin
            bad++; $display("FAIL coinc_short: got lock=%b act=%b st=%0d want 0/0/MEASURE", timing_lock, mode_active, dut.state_r); end
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < int'(TB_V) - 1; i++) send_line(int'(TB_H));
            send_line_coinc(int'(TB_H));
            total++; if (v_act_meas !== 12'(m_v) || timing_lock !== (m_lock == TB_LOCK)) begin
                bad++; $display("FAIL coinc f%0d: got v=%0d lock=%b want %0d/%b", f, v_act_meas, timing_lock, m_v, m_lock == TB_LOCK); end
        end
    endtask

    task automatic test_random_frames();
        int kind, nl, bi, len;
        for (int f = 0; f < 10; f++) begin
            kind = $urandom_range(0, 3);
            nl = int'(TB_V);
            if (kind == 1) nl = int'(TB_V) - 1 + 2 * int'($urandom_range(0, 1));
            bi = $urandom_range(0, nl - 1);
            for (int i = 0; i < nl; i++) begin
                len = int'(TB_H);
                if (kind == 2 && i == bi) len = $urandom_range(1, int'(TB_H) + 3);
                if (f == 0 && i == 0) len = 4100;
                if (kind == 3 && i == nl - 1) send_line_coinc(len);
                else send_line(len);
            end
            if (kind != 3) send_vs();
            total++; if (h_act_meas !== 12'(m_h) || v_act_meas !== 12'(m_v) || timing_lock !== (m_lock == TB_LOCK)) begin
                bad++; $display("FAIL rand f%0d k%0d: got h=%0d v=%0d lock=%b want %0d/%0d/%b", f, kind,
                    h_act_meas, v_act_meas, timing_lock, m_h, m_v, m_lock == TB_LOCK); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_cancel();
        test_mode_switch();
        test_timing_fault();
        test_abort(1'b0);
        test_abort(1'b1);
        test_coincident();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
